// File: rtl/regex_ctx_pkg.sv
// Shared types and helpers for the per-stream regex context manager.
// Holds the controller state encoding and the saturating increment used by the counters.
package regex_ctx_pkg;

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        IDLE  = 2'd1,
        PKT   = 2'd2
    } ctx_state_e;

    // Adds inc to value, holding at 2^width-1; callers cast the result to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc,
                                            input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32'd32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (inc && (value < max_v)) begin
            return value + 32'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/regex_ctx_ram.sv
// Generic one-write/one-read synchronous RAM with a registered read port.
// A read and write to the same address in one cycle returns the old contents.
module regex_ctx_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream save/restore of regex engine state with commit-at-EOP and saturating match counts.
// A sweep zeroes every context after reset or clear_all_i; inputs other than clear are ignored meanwhile.
module regex_stream_ctx
    import regex_ctx_pkg::*;
#(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = $clog2(NUM_STREAMS),
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_all_i,
    input  logic               load_state_i,
    input  logic [SID_W-1:0]   stream_id_i,
    input  logic               new_stream_id_i,
    input  logic               enable_i,
    input  logic               eop_i,
    input  logic [STATE_W-1:0] eng_state_out_i,
    input  logic               eng_accept_i,
    output logic [STATE_W-1:0] eng_state_in_o,
    output logic               eng_state_in_vld_o,
    output logic               fired_o,
    output logic               busy_o,
    input  logic [SID_W-1:0]   rd_sid_i,
    output logic [COUNT_W-1:0] rd_count_o,
    output logic [COUNT_W-1:0] total_count_o
);

    localparam logic [SID_W-1:0] LAST_IDX = SID_W'(NUM_STREAMS - 1);

    ctx_state_e         state_q, state_d;
    logic [SID_W-1:0]   idx_q, idx_d;
    logic               ld_go_s, eop_go_s, commit_go_s, hit_s, sweep_s, fired_d;
    logic [SID_W-1:0]   pkt_sid_q;
    logic               rst_vld_q, rst_new_q, byp_q, fetch_q, fbyp_q, fired_q, rd_vld_q;
    logic [STATE_W-1:0] byp_data_q, st_rdata_s;
    logic [COUNT_W-1:0] cnt_q, fbyp_data_q, total_q, rd_hold_q;
    logic [COUNT_W-1:0] cnt_rdata_s, cur_cnt_s, cnt_new_s, total_new_s, rd_count_s;

    // Controller next state and the accepted load/eop strobes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ld_go_s  = 1'b0;
        eop_go_s = 1'b0;
        if (clear_all_i) begin
            state_d = SWEEP;
            idx_d   = '0;
        end else begin
            case (state_q)
                SWEEP: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + SID_W'(1);
                    end
                end
                IDLE: begin
                    if (load_state_i) begin
                        ld_go_s = 1'b1;
                        state_d = PKT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PKT: begin
                    ld_go_s  = load_state_i;
                    eop_go_s = eop_i;
                    if (eop_i && !load_state_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PKT;
                    end
                end
                default: begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign sweep_s     = (state_q == SWEEP);
    assign commit_go_s = eop_go_s & enable_i;
    assign hit_s       = fired_q | eng_accept_i;

    // A one-cycle packet commits before the fetched count reaches cnt_q, so use the fetch path directly.
    assign cur_cnt_s   = fetch_q ? (fbyp_q ? fbyp_data_q : cnt_rdata_s) : cnt_q;
    assign cnt_new_s   = COUNT_W'(sat_inc(32'(cur_cnt_s), hit_s, COUNT_W));
    assign total_new_s = COUNT_W'(sat_inc(32'(total_q), hit_s, COUNT_W));

    // Speculative match flag for the open packet.
    always_comb begin
        fired_d = fired_q;
        if (clear_all_i || sweep_s) begin
            fired_d = 1'b0;
        end else if (ld_go_s || eop_go_s) begin
            fired_d = 1'b0;
        end else begin
            fired_d = fired_q | eng_accept_i;
        end
    end

    regex_ctx_ram #(.WIDTH(STATE_W), .DEPTH(NUM_STREAMS), .AW(SID_W)) u_state_mem (
        .clk     (clk),
        .we_i    (sweep_s | commit_go_s),
        .waddr_i (sweep_s ? idx_q : pkt_sid_q),
        .wdata_i (sweep_s ? '0 : eng_state_out_i),
        .raddr_i (stream_id_i),
        .rdata_o (st_rdata_s)
    );

    // A load borrows the count read port for one cycle to fetch the running count; rd_count_o holds then.
    regex_ctx_ram #(.WIDTH(COUNT_W), .DEPTH(NUM_STREAMS), .AW(SID_W)) u_count_mem (
        .clk     (clk),
        .we_i    (sweep_s | commit_go_s),
        .waddr_i (sweep_s ? idx_q : pkt_sid_q),
        .wdata_i (sweep_s ? '0 : cnt_new_s),
        .raddr_i (ld_go_s ? stream_id_i : rd_sid_i),
        .rdata_o (cnt_rdata_s)
    );

    // Packet context, restore/bypass capture, counters and readback hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_sid_q   <= '0;
            rst_vld_q   <= 1'b0;
            rst_new_q   <= 1'b0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
            fetch_q     <= 1'b0;
            fbyp_q      <= 1'b0;
            fbyp_data_q <= '0;
            cnt_q       <= '0;
            fired_q     <= 1'b0;
            total_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            if (ld_go_s) begin
                pkt_sid_q <= stream_id_i;
            end
            rst_vld_q   <= ld_go_s;
            rst_new_q   <= new_stream_id_i;
            byp_q       <= commit_go_s && (pkt_sid_q == stream_id_i);
            byp_data_q  <= eng_state_out_i;
            fetch_q     <= ld_go_s;
            fbyp_q      <= commit_go_s && (pkt_sid_q == stream_id_i);
            fbyp_data_q <= cnt_new_s;
            cnt_q       <= cur_cnt_s;
            fired_q     <= fired_d;
            rd_vld_q    <= 1'b1;
            rd_hold_q   <= rd_count_s;
            if (clear_all_i) begin
                total_q <= '0;
            end else if (commit_go_s) begin
                total_q <= total_new_s;
            end
        end
    end

    assign rd_count_s = !rd_vld_q ? '0 : (fetch_q ? rd_hold_q : cnt_rdata_s);

    assign eng_state_in_o     = rst_vld_q ? (rst_new_q ? '0 : (byp_q ? byp_data_q : st_rdata_s)) : '0;
    assign eng_state_in_vld_o = rst_vld_q;
    assign fired_o            = fired_q;
    assign busy_o             = sweep_s;
    assign rd_count_o         = rd_count_s;
    assign total_count_o      = total_q;

endmodule
